// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the LR35902 instruction fetch unit and its trace/disassembler models.
// Covers fetch states, the instruction bundle and the opcode length/illegal tables.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        IFS_FETCH_OP   = 3'd0,
        IFS_FETCH_CB   = 3'd1,
        IFS_FETCH_OPR1 = 3'd2,
        IFS_FETCH_OPR2 = 3'd3,
        IFS_HOLD       = 3'd4,
        IFS_STALL      = 3'd5
    } ifetch_state_e;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef struct packed {
        logic [23:0] bytes;
        logic [1:0]  len;
        logic        cb;
        logic        illegal;
        logic [15:0] pc;
    } instr_bundle_t;

    // Bytes consumed from memory; a CB-prefixed instruction always takes two.
    function automatic logic [1:0] instr_len_f(input logic [7:0] opcode);
        logic [1:0] len;
        case (opcode)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8, CB_PREFIX:         len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
            8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:                                  len = 2'd3;
            default:                                       len = 2'd1;
        endcase
        return len;
    endfunction

    function automatic logic is_illegal_f(input logic [7:0] opcode);
        logic ill;
        case (opcode)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
            default:                           ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read bus, redirect input and instruction output of the fetch unit.
// master = fetch unit side, slave = memory/execute side.
interface instr_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] instr_bytes;
    logic [1:0]  instr_len;
    logic        instr_cb;
    logic        instr_illegal;
    logic [15:0] instr_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_bytes, instr_len,
               instr_cb, instr_illegal, instr_pc,
        input  mem_rdata, mem_ack, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_bytes, instr_len,
               instr_cb, instr_illegal, instr_pc,
        output mem_rdata, mem_ack, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_len_decode.sv
// Combinational opcode length decoder, shared with the disassembler/trace model.
module ifetch_len_decode
    import instr_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic       cb,
    output logic       illegal
);
    assign len     = instr_len_f(opcode);
    assign cb      = (opcode == CB_PREFIX);
    assign illegal = is_illegal_f(opcode);
endmodule

// File: rtl/instr_fetch.sv
// LR35902 instruction fetch: reads bytes over req/ack, assembles whole instructions.
// Define IFETCH_PREFETCH_EN to prefetch the next opcode while an instruction is held.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter bit          HOLD_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    instr_fetch_if.master bus
);
`ifdef IFETCH_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    localparam logic [2:0] S_FETCH_OP   = IFS_FETCH_OP;
    localparam logic [2:0] S_FETCH_CB   = IFS_FETCH_CB;
    localparam logic [2:0] S_FETCH_OPR1 = IFS_FETCH_OPR1;
    localparam logic [2:0] S_FETCH_OPR2 = IFS_FETCH_OPR2;
    localparam logic [2:0] S_HOLD       = IFS_HOLD;
    localparam logic [2:0] S_STALL      = IFS_STALL;

    logic [2:0]    state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [7:0]    op_q, op_d;
    logic [7:0]    opr1_q, opr1_d;
    logic [1:0]    len_q, len_d;
    logic [15:0]   ipc_q, ipc_d;
    instr_bundle_t ib_q, ib_d;
    logic          instr_valid_q, instr_valid_d;
    logic          pf_valid_q, pf_valid_d;
    logic [7:0]    pf_byte_q, pf_byte_d;

    logic        fetch_req, mem_req, ack, xfer, stall_after;
    logic        start_en;
    logic [7:0]  start_byte;
    logic [15:0] start_pc;
    logic [1:0]  dec_len;
    logic        dec_cb, dec_ill;

    ifetch_len_decode u_len_decode (
        .opcode  (start_byte),
        .len     (dec_len),
        .cb      (dec_cb),
        .illegal (dec_ill)
    );

    // An illegal instruction in HOLD must not trigger a prefetch: STALL follows it.
    assign stall_after = HOLD_ON_ILLEGAL && ib_q.illegal;

    always_comb begin
        fetch_req = 1'b0;
        case (state_q)
            S_FETCH_OP, S_FETCH_CB, S_FETCH_OPR1, S_FETCH_OPR2: fetch_req = 1'b1;
            S_HOLD:  fetch_req = PF_EN && !pf_valid_q && !stall_after;
            default: fetch_req = 1'b0;
        endcase
    end

    assign mem_req = fetch_req && !reset;
    assign ack     = mem_req && bus.mem_ack;
    assign xfer    = instr_valid_q && bus.instr_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        op_d          = op_q;
        opr1_d        = opr1_q;
        len_d         = len_q;
        ipc_d         = ipc_q;
        ib_d          = ib_q;
        instr_valid_d = instr_valid_q;
        pf_valid_d    = pf_valid_q;
        pf_byte_d     = pf_byte_q;
        start_en      = 1'b0;
        start_byte    = bus.mem_rdata;
        start_pc      = fetch_pc_q;

        if (ack) fetch_pc_d = fetch_pc_q + 16'd1;

        case (state_q)
            S_FETCH_OP: if (ack) start_en = 1'b1;
            S_FETCH_CB: if (ack) begin
                ib_d = '{bytes: {16'h0, bus.mem_rdata}, len: 2'd2, cb: 1'b1,
                         illegal: 1'b0, pc: ipc_q};
                instr_valid_d = 1'b1;
                state_d       = S_HOLD;
            end
            S_FETCH_OPR1: if (ack) begin
                if (len_q == 2'd3) begin
                    opr1_d  = bus.mem_rdata;
                    state_d = S_FETCH_OPR2;
                end else begin
                    ib_d = '{bytes: {8'h0, bus.mem_rdata, op_q}, len: 2'd2, cb: 1'b0,
                             illegal: 1'b0, pc: ipc_q};
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_FETCH_OPR2: if (ack) begin
                ib_d = '{bytes: {bus.mem_rdata, opr1_q, op_q}, len: 2'd3, cb: 1'b0,
                         illegal: 1'b0, pc: ipc_q};
                instr_valid_d = 1'b1;
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                if (ack) begin
                    pf_valid_d = 1'b1;
                    pf_byte_d  = bus.mem_rdata;
                end
                if (xfer) begin
                    instr_valid_d = 1'b0;
                    pf_valid_d    = 1'b0;
                    if (stall_after) begin
                        state_d = S_STALL;
                    end else if (pf_valid_q || ack) begin
                        // A byte acked this very cycle is used directly as the next opcode.
                        start_en   = 1'b1;
                        start_byte = pf_valid_q ? pf_byte_q : bus.mem_rdata;
                        start_pc   = pf_valid_q ? (fetch_pc_q - 16'd1) : fetch_pc_q;
                    end else begin
                        state_d = S_FETCH_OP;
                    end
                end
            end
            S_STALL: ;
            default: state_d = S_FETCH_OP;
        endcase

        if (start_en) begin
            ipc_d = start_pc;
            op_d  = start_byte;
            len_d = dec_len;
            if (dec_cb) begin
                state_d = S_FETCH_CB;
            end else if (dec_len == 2'd1) begin
                ib_d = '{bytes: {16'h0, start_byte}, len: 2'd1, cb: 1'b0,
                         illegal: dec_ill, pc: start_pc};
                instr_valid_d = 1'b1;
                state_d       = S_HOLD;
            end else begin
                state_d = S_FETCH_OPR1;
            end
        end

        if (bus.redirect_valid) begin
            fetch_pc_d    = bus.redirect_pc;
            state_d       = S_FETCH_OP;
            instr_valid_d = 1'b0;
            pf_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH_OP;
            fetch_pc_q    <= RESET_PC;
            op_q          <= 8'h00;
            opr1_q        <= 8'h00;
            len_q         <= 2'd0;
            ipc_q         <= RESET_PC;
            ib_q          <= '{bytes: 24'h0, len: 2'd0, cb: 1'b0, illegal: 1'b0, pc: RESET_PC};
            instr_valid_q <= 1'b0;
            pf_valid_q    <= 1'b0;
            pf_byte_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            op_q          <= op_d;
            opr1_q        <= opr1_d;
            len_q         <= len_d;
            ipc_q         <= ipc_d;
            ib_q          <= ib_d;
            instr_valid_q <= instr_valid_d;
            pf_valid_q    <= pf_valid_d;
            pf_byte_q     <= pf_byte_d;
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_addr      = fetch_pc_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr_bytes   = ib_q.bytes;
    assign bus.instr_len     = ib_q.len;
    assign bus.instr_cb      = ib_q.cb;
    assign bus.instr_illegal = ib_q.illegal;
    assign bus.instr_pc      = ib_q.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized ack/ready/redirect traffic,
// every transfer checked against a memory-walking reference of the instruction stream.
module tb_instr_fetch;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam bit          HOLD_ILL = 1'b1;

    logic clk;
    logic reset;
    logic [7:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [15:0] exp_pc;
    bit stalled;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(RESET_PC), .HOLD_ON_ILLEGAL(HOLD_ILL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA, 8'hD2,
                       8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA})
            return 3;
        if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
                       8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
                       8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB})
            return 2;
        return 1;
    endfunction

    function automatic bit ref_illegal(input logic [7:0] op);
        return op inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                          8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
    endfunction

    // Reference: the next accepted instruction must be the one starting at exp_pc.
    task automatic model_xfer();
        logic [15:0] p1, p2;
        logic [7:0]  op;
        logic [23:0] eb;
        int el;
        bit ecb, eill;
        p1 = exp_pc + 16'd1;
        p2 = exp_pc + 16'd2;
        op = mem[exp_pc];
        ecb = 1'b0;
        eill = 1'b0;
        if (op == 8'hCB) begin
            ecb = 1'b1;
            el  = 2;
            eb  = {16'h0, mem[p1]};
        end else begin
            el   = ref_len(op);
            eill = ref_illegal(op);
            eb   = {16'h0, op};
            if (el >= 2) eb[15:8]  = mem[p1];
            if (el == 3) eb[23:16] = mem[p2];
        end
        $display("xfer pc=%h bytes=%h len=%0d cb=%0b ill=%0b", bus.instr_pc,
                 bus.instr_bytes, bus.instr_len, bus.instr_cb, bus.instr_illegal);
        check_eq("xfer_pc", bus.instr_pc, exp_pc);
        check_eq("xfer_bytes", bus.instr_bytes, eb);
        check_eq("xfer_len", bus.instr_len, el);
        check_eq("xfer_cb", bus.instr_cb, ecb);
        check_eq("xfer_illegal", bus.instr_illegal, eill);
        exp_pc = exp_pc + 16'(el);
        if (eill && HOLD_ILL) stalled = 1'b1;
        n_xfer++;
    endtask

    task automatic step();
        logic hold_chk, req_chk;
        logic [23:0] h_bytes;
        logic [15:0] h_pc, r_addr;
        logic [1:0]  h_len;
        hold_chk = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid && !reset;
        h_bytes  = bus.instr_bytes;
        h_pc     = bus.instr_pc;
        h_len    = bus.instr_len;
        req_chk  = bus.mem_req && !bus.mem_ack && !bus.redirect_valid && !reset;
        r_addr   = bus.mem_addr;
        if (!reset && bus.instr_valid && bus.instr_ready) model_xfer();
        if (reset) begin
            exp_pc  = RESET_PC;
            stalled = 1'b0;
        end else if (bus.redirect_valid) begin
            exp_pc  = bus.redirect_pc;
            stalled = 1'b0;
        end
        @(posedge clk);
        #1;
        if (hold_chk) begin
            check_eq("hold_valid", bus.instr_valid, 1);
            check_eq("hold_bytes", bus.instr_bytes, h_bytes);
            check_eq("hold_pc", bus.instr_pc, h_pc);
            check_eq("hold_len", bus.instr_len, h_len);
        end
        if (req_chk) check_eq("req_held", {bus.mem_req, bus.mem_addr}, {1'b1, r_addr});
        if (stalled) check_eq("stall_idle", {bus.mem_req, bus.instr_valid}, 0);
    endtask

    task automatic redirect(input logic [15:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.instr_valid && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, bus.instr_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        exp_pc = RESET_PC;
        stalled = 1'b0;
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h1234;

        // 1: reset values (redirect ignored while in reset), 1-byte latency
        step();
        step();
        check_eq("rst_valid", bus.instr_valid, 0);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_bytes", bus.instr_bytes, 0);
        check_eq("rst_len", bus.instr_len, 0);
        check_eq("rst_cb_ill", {bus.instr_cb, bus.instr_illegal}, 0);
        check_eq("rst_pc", bus.instr_pc, RESET_PC);
        check_eq("rst_addr", bus.mem_addr, RESET_PC);
        bus.redirect_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("c0_req", bus.mem_req, 1);
        step();
        check_eq("t1_valid", bus.instr_valid, 1);
        check_eq("t1_bytes", bus.instr_bytes, 24'h000000);
        check_eq("t1_len", bus.instr_len, 1);
        check_eq("t1_pc", bus.instr_pc, 16'h0000);

        // 2: 3-byte instruction from reset
        mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        step(); step();
        check_eq("t2_early", bus.instr_valid, 0);
        step();
        check_eq("t2_valid", bus.instr_valid, 1);
        check_eq("t2_bytes", bus.instr_bytes, 24'h0150C3);
        check_eq("t2_len", bus.instr_len, 3);
        check_eq("t2_pc", bus.instr_pc, 16'h0000);
        step();
        check_eq("t2_next_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0003});

        // 3: CB-prefixed instruction via redirect
        mem[16'h0010] = 8'hCB; mem[16'h0011] = 8'h37;
        bus.instr_ready = 1'b0;
        redirect(16'h0010);
        wait_valid("t3_valid");
        check_eq("t3_cb", bus.instr_cb, 1);
        check_eq("t3_bytes", bus.instr_bytes, 24'h000037);
        check_eq("t3_len", bus.instr_len, 2);
        check_eq("t3_pc", bus.instr_pc, 16'h0010);
        bus.instr_ready = 1'b1;
        step();

        // 4: back-pressure, then redirect in the middle of a 3-byte fetch
        mem[16'h0020] = 8'h3E; mem[16'h0021] = 8'h42;
        mem[16'h0030] = 8'h01; mem[16'h0031] = 8'h34; mem[16'h0032] = 8'h12;
        bus.instr_ready = 1'b0;
        redirect(16'h0020);
        wait_valid("t4_valid");
        for (int i = 0; i < 5; i++) begin
            step();
`ifndef IFETCH_PREFETCH_EN
            check_eq("t4_no_req", bus.mem_req, 0);
`endif
        end
        check_eq("t4_bytes", bus.instr_bytes, 24'h00423E);
        bus.instr_ready = 1'b1;
        step();
        redirect(16'h0030);
        step();
        check_eq("t4_in_opr1", bus.mem_addr, 16'h0031);
        redirect(16'h0200);
        check_eq("t4_redir_addr", bus.mem_addr, 16'h0200);
        check_eq("t4_redir_valid", bus.instr_valid, 0);
        wait_valid("t4b_valid");
        check_eq("t4b_pc", bus.instr_pc, 16'h0200);

        // 5: instruction straddling the FFFF -> 0000 wrap
        bus.instr_ready = 1'b0;
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h77; mem[16'h0001] = 8'h00;
        redirect(16'hFFFF);
        wait_valid("t5_valid");
        check_eq("t5_pc", bus.instr_pc, 16'hFFFF);
        check_eq("t5_bytes", bus.instr_bytes, 24'h00773E);
        check_eq("t5_len", bus.instr_len, 2);
        bus.instr_ready = 1'b1;
        step();
        check_eq("t5_wrap_addr", bus.mem_addr, 16'h0001);

        // 6: illegal opcode stalls until redirect, then a stream of 1-byte NOPs
        bus.instr_ready = 1'b0;
        mem[16'h0040] = 8'hD3;
        redirect(16'h0040);
        wait_valid("t6_valid");
        check_eq("t6_illegal", bus.instr_illegal, 1);
        check_eq("t6_bytes", bus.instr_bytes, 24'h0000D3);
        check_eq("t6_len", bus.instr_len, 1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_stall", {bus.mem_req, bus.instr_valid}, 0);
        redirect(16'h0050);
        wait_valid("t6b_valid");
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef IFETCH_PREFETCH_EN
            check_eq("t6_stream", bus.instr_valid, 1);
`else
            check_eq("t6_stream", bus.instr_valid, (i % 2) == 1);
`endif
        end

        // Random traffic over a random code region
        for (int a = 16'h1000; a < 16'h1800; a++) mem[a] = 8'($urandom);
        redirect(16'h1000);
        for (int c = 0; c < 2500; c++) begin
            bus.mem_ack     = ($urandom_range(0, 3) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            if ((stalled && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 16'h1000 + 16'($urandom_range(0, 16'h700));
            end else begin
                bus.redirect_valid = 1'b0;
            end
            step();
        end
        bus.redirect_valid = 1'b0;
        check_eq("xfer_count_min", n_xfer > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
